pixel_frame_source: RTL

Upstream producer for the dual-clock pixel FIFO: generates raster frames of IMG_W x IMG_H pixels from a selectable test pattern and pushes them into the FIFO write port in the wr_clk domain. It honours the FIFO `full` backpressure, inserts programmable line and frame blanking, and reports frame completion and stall statistics. It is the source that drives the pixel processing path and its benches.

---
 rtl/pixel_frame_source.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_source.sv
// Raster test-pattern source feeding the write port of the dual-clock pixel FIFO.
// Walks IMG_W x IMG_H frames, honours fifo_full, and inserts line/frame blanking.
module pixel_frame_source #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int LINE_GAP   = 2,
  parameter int FRAME_GAP  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      stall_count,
  output logic [1:0]            dbg_state
);

  // Handshake: a pixel moves on every wr_clk edge where fifo_wr_en is high;
  // fifo_wr_en is the combinational inverse of fifo_full while ACTIVE, and
  // fifo_wr_data stays stable until that pixel is taken.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_LGAP   = 2'd2,
    S_FGAP   = 2'd3
  } state_t;

  localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam logic [GAP_W-1:0] LGAP_LAST = GAP_W'(LINE_GAP - 1);
  localparam logic [GAP_W-1:0] FGAP_LAST = GAP_W'(FRAME_GAP - 1);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 1);
  localparam logic [7:0]       LFSR_SEED = 8'hE1;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        col_q, col_d;
  logic [CNT_W-1:0]        row_q, row_d;
  logic [1:0]              pat_q, pat_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]   ramp_q, ramp_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]        scnt_q, scnt_d;

  logic                    active;
  logic                    accept;
  logic                    start_frame;
  logic                    lfsr_fb;
  logic [DATA_WIDTH-1:0]   pix;

  assign active  = (state_q == S_ACTIVE);
  assign accept  = active && !fifo_full;
  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 on a left-shifting register.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      pat_q   <= '0;
      lfsr_q  <= '0;
      ramp_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      ramp_q  <= ramp_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pat_d       = pat_q;
    lfsr_d      = lfsr_q;
    ramp_d      = ramp_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    fcnt_d      = fcnt_q;
    start_frame = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      S_ACTIVE: begin
        if (accept) begin
          lfsr_d = {lfsr_q[6:0], lfsr_fb};
          ramp_d = ramp_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              done_d = 1'b1;
              fcnt_d = fcnt_q + 1'b1;
              // With no frame gap the exit decision is taken on this same edge.
              if (FRAME_GAP == 0) begin
                if (enable) start_frame = 1'b1;
                else        state_d     = S_IDLE;
              end else begin
                state_d = S_FGAP;
                gap_d   = '0;
              end
            end else begin
              row_d = row_q + 1'b1;
              if (LINE_GAP != 0) begin
                state_d = S_LGAP;
                gap_d   = '0;
              end
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_LGAP: begin
        if (gap_q == LGAP_LAST) state_d = S_ACTIVE;
        else                    gap_d   = gap_q + 1'b1;
      end
      S_FGAP: begin
        if (gap_q == FGAP_LAST) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d = S_ACTIVE;
      col_d   = '0;
      row_d   = '0;
      pat_d   = pattern_sel;
      lfsr_d  = LFSR_SEED;
      ramp_d  = '0;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (active && fifo_full && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + 1'b1;
  end

  always_comb begin
    pix = '0;
    case (pat_q)
      2'b00:   pix = ramp_q;
      2'b01:   pix = DATA_WIDTH'(col_q);
      2'b10:   pix = DATA_WIDTH'(lfsr_q);
      default: pix = {DATA_WIDTH{col_q[0] ^ row_q[0]}};
    endcase
  end

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = active ? pix : '0;
  assign frame_done   = done_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_count  = fcnt_q;
  assign stall_count  = scnt_q;
  assign dbg_state    = state_q;

endmodule
